apu_length_envelope: RTL and testbench
======================================

Name: apu_length_envelope

Overview:
- Per-channel length and volume-envelope control in the APU, directly downstream of the 256 Hz enable generator; consumes its single-cycle `clk256_en` strobe.
- Derives the 64 Hz envelope tick internally, runs the length counter at 256 Hz, and produces the channel's current 4-bit volume and on/off status for the channel mixer.
- Instantiated once per square/noise channel (LEN_WIDTH=6) and for the wave channel (LEN_WIDTH=8, envelope outputs unused).

Parameters:
- LEN_WIDTH, 6, length counter data width; counter holds up to 2^LEN_WIDTH.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- clk256_en  input  1  one-cycle 256 Hz strobe from the upstream generator
- trigger  input  1  one-cycle channel trigger (NRx4 bit 7 write)
- length_load  input  1  one-cycle length register write strobe
- length_data  input  LEN_WIDTH  length register value
- length_enable  input  1  length counting enabled (NRx4 bit 6)
- dac_enable  input  1  channel DAC powered
- env_init_vol  input  4  initial envelope volume
- env_dir  input  1  1 = increase, 0 = decrease
- env_period  input  3  envelope period in 64 Hz ticks; 0 = envelope frozen
- volume  output  4  current envelope volume
- channel_on  output  1  channel active status

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - volume=0, channel_on=0.
  - Length counter (LEN_WIDTH+1 bits)=0.
  - Envelope timer=0.
  - 2-bit divider=0.
- Divider:
  - Increments on each `clk256_en`; wraps 3→0.
  - `env_tick` = `clk256_en` && divider==3, i.e. one tick per 4 strobes.
  - Free-running; not cleared by trigger.
- Length counter:
  - `length_load`: counter <= 2^LEN_WIDTH − length_data. Loading 0 gives 2^LEN_WIDTH.
  - On `clk256_en` with length_enable=1 and counter≠0: counter decrements. On the transition 1→0, channel_on <= 0 in the same edge.
  - Counter at 0 stays at 0; no wrap.
- Envelope:
  - On `env_tick` with env_period≠0: timer decrements.
  - When the timer is 1 or 0 at the tick: timer <= env_period, and volume steps by one in env_dir direction.
  - Volume saturates at 15 going up and at 0 going down; no wrap.
  - env_period=0: timer and volume hold.
- Trigger (registered, takes effect at the next edge):
  - channel_on <= dac_enable.
  - If the length counter is 0, it becomes 2^LEN_WIDTH.
  - volume <= env_init_vol; timer <= env_period.
- Precedence and simultaneous events:
  - trigger together with `clk256_en`/`env_tick`: the trigger reload wins; that cycle's length decrement and envelope step are suppressed. The divider still advances.
  - length_load together with trigger: the load is applied first, so the trigger sees a nonzero counter and does not reload 2^LEN_WIDTH.
  - length_load together with `clk256_en`: the load wins; no decrement.
- DAC gating:
  - dac_enable=0 forces channel_on <= 0 at the next edge, overriding trigger.
  - Volume and counters continue to update.
- Latency: every output is registered, so a response appears one clk after the causing strobe.
- Reset mid-operation: asserting reset at any point returns all state to reset values asynchronously. Releasing reset resumes with the divider phase at 0.

Test Plan:
- Reset/idle: reset asserted mid-count, then released with no strobes → volume=0, channel_on=0; outputs remain 0 through 100 `clk256_en` strobes.
- Length expiry: length_data=60 load, then trigger with dac_enable=1, length_enable=1 → channel_on=1; it drops to 0 exactly on the 4th `clk256_en` after the trigger.
- Length zero reload: counter expired to 0, then trigger → counter=64. With length_enable=1, channel_on falls after 64 strobes.
- Envelope decrease/saturate: env_init_vol=3, dir=0, period=1, trigger → volume goes 3,2,1,0 on successive `env_tick`s (every 4 `clk256_en`), then stays 0.
- Envelope increase/freeze: init=14, dir=1, period=2 → volume 15 after 8 strobes, then holds at 15. Repeat with period=0 → volume stays 14.
- Simultaneous events: trigger coincident with the 4th `clk256_en` → no envelope step or length decrement that cycle; volume=env_init_vol. Separately, dac_enable=0 with trigger → channel_on remains 0.

Source files
------------

// File: rtl/apu_length_envelope_if.sv
// Control and status bundle between an APU channel's register block and its
// length/envelope unit.
interface apu_length_envelope_if #(
  parameter int LEN_WIDTH = 6
);
  logic                 clk256_en;
  logic                 trigger;
  logic                 length_load;
  logic [LEN_WIDTH-1:0] length_data;
  logic                 length_enable;
  logic                 dac_enable;
  logic [3:0]           env_init_vol;
  logic                 env_dir;
  logic [2:0]           env_period;
  logic [3:0]           volume;
  logic                 channel_on;

  modport master (
    output clk256_en, trigger, length_load, length_data, length_enable,
           dac_enable, env_init_vol, env_dir, env_period,
    input  volume, channel_on
  );

  modport slave (
    input  clk256_en, trigger, length_load, length_data, length_enable,
           dac_enable, env_init_vol, env_dir, env_period,
    output volume, channel_on
  );
endinterface

// File: rtl/apu_length_envelope.sv
// Per-channel length counter and volume envelope, stepped by the 256 Hz strobe
// with a 64 Hz envelope tick derived locally.
module apu_length_envelope #(
  parameter int LEN_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  apu_length_envelope_if.slave   bus
);
  localparam int CW = LEN_WIDTH + 1;
  localparam logic [CW-1:0] LEN_FULL = {1'b1, {LEN_WIDTH{1'b0}}};

  logic [1:0]    div_q;
  logic [CW-1:0] len_cnt_q, len_cnt_d;
  logic [2:0]    env_timer_q, env_timer_d;
  logic [3:0]    volume_q, volume_d;
  logic          channel_on_q, channel_on_d;

  logic          env_tick;
  logic          len_dec;
  logic [CW-1:0] len_load_val;

  function automatic logic [3:0] env_step(input logic [3:0] vol, input logic up);
    if (up) return (vol == 4'hF) ? vol : vol + 4'd1;
    else    return (vol == 4'h0) ? vol : vol - 4'd1;
  endfunction

  assign env_tick     = bus.clk256_en && (div_q == 2'd3);
  assign len_load_val = LEN_FULL - {1'b0, bus.length_data};
  // Trigger and register loads both pre-empt the strobe's decrement.
  assign len_dec      = bus.clk256_en && bus.length_enable && (len_cnt_q != '0)
                        && !bus.trigger && !bus.length_load;

  always_comb begin
    len_cnt_d = len_cnt_q;
    if (bus.length_load)
      len_cnt_d = len_load_val;
    else if (bus.trigger && (len_cnt_q == '0))
      len_cnt_d = LEN_FULL;
    else if (len_dec)
      len_cnt_d = len_cnt_q - CW'(1);
  end

  always_comb begin
    channel_on_d = channel_on_q;
    if (bus.trigger)
      channel_on_d = 1'b1;
    else if (len_dec && (len_cnt_q == CW'(1)))
      channel_on_d = 1'b0;
    if (!bus.dac_enable)
      channel_on_d = 1'b0;
  end

  always_comb begin
    env_timer_d = env_timer_q;
    volume_d    = volume_q;
    if (bus.trigger) begin
      env_timer_d = bus.env_period;
      volume_d    = bus.env_init_vol;
    end else if (env_tick && (bus.env_period != 3'd0)) begin
      if (env_timer_q <= 3'd1) begin
        env_timer_d = bus.env_period;
        volume_d    = env_step(volume_q, bus.env_dir);
      end else begin
        env_timer_d = env_timer_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q        <= 2'd0;
      len_cnt_q    <= '0;
      env_timer_q  <= 3'd0;
      volume_q     <= 4'd0;
      channel_on_q <= 1'b0;
    end else begin
      if (bus.clk256_en)
        div_q <= div_q + 2'd1;
      len_cnt_q    <= len_cnt_d;
      env_timer_q  <= env_timer_d;
      volume_q     <= volume_d;
      channel_on_q <= channel_on_d;
    end
  end

  assign bus.volume     = volume_q;
  assign bus.channel_on = channel_on_q;
endmodule

// File: tb/tb_apu_length_envelope.sv
// Directed bench for apu_length_envelope (LEN_WIDTH=6).
module tb_apu_length_envelope;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  apu_length_envelope_if #(.LEN_WIDTH(6)) bus ();

  apu_length_envelope #(.LEN_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    bus.clk256_en     = 1'b0;
    bus.trigger       = 1'b0;
    bus.length_load   = 1'b0;
    bus.length_data   = 6'd0;
    bus.length_enable = 1'b0;
    bus.dac_enable    = 1'b0;
    bus.env_init_vol  = 4'd0;
    bus.env_dir       = 1'b0;
    bus.env_period    = 3'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock with the given strobes high; returns at the following negedge.
  task automatic cycle(input logic trig, input logic load, input logic s256);
    @(negedge clk);
    bus.trigger     = trig;
    bus.length_load = load;
    bus.clk256_en   = s256;
    @(negedge clk);
    bus.trigger     = 1'b0;
    bus.length_load = 1'b0;
    bus.clk256_en   = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.volume !== 4'd0 || bus.channel_on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: volume=%0d on=%b expected volume=0 on=0", bus.volume, bus.channel_on);
    end
    reset = 1'b1;
    bus.dac_enable = 1'b1; bus.env_init_vol = 4'd5; bus.length_data = 6'd0;
    bus.length_enable = 1'b1; bus.env_period = 3'd1;
    cycle(1'b1, 1'b0, 1'b0);
    strobes(2);
    n_cmp++;
    if (bus.volume !== 4'd5 || bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_run: volume=%0d on=%b expected volume=5 on=1", bus.volume, bus.channel_on);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.volume !== 4'd0 || bus.channel_on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: volume=%0d on=%b expected volume=0 on=0", bus.volume, bus.channel_on);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.env_dir = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (bus.volume !== 4'd0 || bus.channel_on !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: volume=%0d on=%b expected volume=0 on=0", i, bus.volume, bus.channel_on);
      end
    end
  endtask

  task automatic test_length_expiry();
    do_reset();
    bus.dac_enable = 1'b1; bus.length_enable = 1'b1; bus.length_data = 6'd60;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL len_trigger_on: on=%b expected 1", bus.channel_on);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (bus.channel_on !== (i < 4)) begin
        n_fail++;
        $display("FAIL len_expiry_strobe%0d: on=%b expected %b", i, bus.channel_on, (i < 4));
      end
    end
  endtask

  // Continues from the expired counter left by test_length_expiry.
  task automatic test_length_zero_reload();
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL len_zero_trigger: on=%b expected 1", bus.channel_on);
    end
    strobes(63);
    n_cmp++;
    if (bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL len_zero_63: on=%b expected 1", bus.channel_on);
    end
    strobes(1);
    n_cmp++;
    if (bus.channel_on !== 1'b0) begin
      n_fail++;
      $display("FAIL len_zero_64: on=%b expected 0", bus.channel_on);
    end
  endtask

  task automatic test_env_decrease();
    logic [3:0] exp_vol [5];
    logic [3:0] prev;
    exp_vol = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    do_reset();
    bus.dac_enable = 1'b1; bus.env_init_vol = 4'd3; bus.env_dir = 1'b0; bus.env_period = 3'd1;
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.volume !== 4'd3) begin
      n_fail++;
      $display("FAIL env_dec_init: volume=%0d expected 3", bus.volume);
    end
    prev = 4'd3;
    for (int t = 0; t < 5; t++) begin
      strobes(3);
      n_cmp++;
      if (bus.volume !== prev) begin
        n_fail++;
        $display("FAIL env_dec_hold%0d: volume=%0d expected %0d", t, bus.volume, prev);
      end
      strobes(1);
      n_cmp++;
      if (bus.volume !== exp_vol[t]) begin
        n_fail++;
        $display("FAIL env_dec_tick%0d: volume=%0d expected %0d", t, bus.volume, exp_vol[t]);
      end
      prev = exp_vol[t];
    end
  endtask

  task automatic test_env_increase();
    do_reset();
    bus.dac_enable = 1'b1; bus.env_init_vol = 4'd14; bus.env_dir = 1'b1; bus.env_period = 3'd2;
    cycle(1'b1, 1'b0, 1'b0);
    strobes(4);
    n_cmp++;
    if (bus.volume !== 4'd14) begin
      n_fail++;
      $display("FAIL env_inc_4: volume=%0d expected 14", bus.volume);
    end
    strobes(4);
    n_cmp++;
    if (bus.volume !== 4'd15) begin
      n_fail++;
      $display("FAIL env_inc_8: volume=%0d expected 15", bus.volume);
    end
    strobes(16);
    n_cmp++;
    if (bus.volume !== 4'd15) begin
      n_fail++;
      $display("FAIL env_inc_sat: volume=%0d expected 15", bus.volume);
    end
    bus.env_period = 3'd0;
    cycle(1'b1, 1'b0, 1'b0);
    strobes(16);
    n_cmp++;
    if (bus.volume !== 4'd14) begin
      n_fail++;
      $display("FAIL env_freeze: volume=%0d expected 14", bus.volume);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.dac_enable = 1'b1; bus.length_enable = 1'b1; bus.length_data = 6'd54;
    bus.env_init_vol = 4'd9; bus.env_dir = 1'b0; bus.env_period = 3'd1;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    strobes(3);
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bus.volume !== 4'd9 || bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_trig_tick: volume=%0d on=%b expected volume=9 on=1", bus.volume, bus.channel_on);
    end
    strobes(3);
    n_cmp++;
    if (bus.volume !== 4'd9) begin
      n_fail++;
      $display("FAIL sim_div_phase: volume=%0d expected 9", bus.volume);
    end
    strobes(1);
    n_cmp++;
    if (bus.volume !== 4'd8) begin
      n_fail++;
      $display("FAIL sim_next_tick: volume=%0d expected 8", bus.volume);
    end
    strobes(2);
    n_cmp++;
    if (bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_len_no_dec: on=%b expected 1", bus.channel_on);
    end
    strobes(1);
    n_cmp++;
    if (bus.channel_on !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_len_expire: on=%b expected 0", bus.channel_on);
    end
    // Counter is now 0: a load with the trigger must give 2, not 64.
    bus.length_data = 6'd62;
    cycle(1'b1, 1'b1, 1'b0);
    strobes(1);
    n_cmp++;
    if (bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_load_trig1: on=%b expected 1", bus.channel_on);
    end
    strobes(1);
    n_cmp++;
    if (bus.channel_on !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_load_trig2: on=%b expected 0", bus.channel_on);
    end
    // Load coincident with a strobe: counter becomes 2 with no decrement.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    strobes(1);
    n_cmp++;
    if (bus.channel_on !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_load_strobe: on=%b expected 1", bus.channel_on);
    end
    bus.dac_enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.channel_on !== 1'b0) begin
      n_fail++;
      $display("FAIL dac_off_running: on=%b expected 0", bus.channel_on);
    end
    bus.env_init_vol = 4'd11;
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.channel_on !== 1'b0 || bus.volume !== 4'd11) begin
      n_fail++;
      $display("FAIL dac_off_trigger: on=%b volume=%0d expected on=0 volume=11", bus.channel_on, bus.volume);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_length_expiry();
    test_length_zero_reload();
    test_env_decrease();
    test_env_increase();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
